// File: rtl/div_arb_seq_if.sv
// Handshake bundle for div_arb_seq: two operand requesters and one result consumer.
interface div_arb_seq_if #(
    parameter int unsigned WIDTH = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_dividend;
    logic [WIDTH-1:0] req0_divisor;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_dividend;
    logic [WIDTH-1:0] req1_divisor;
    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             busy;

    modport master (
        output req0_valid, req0_dividend, req0_divisor,
        output req1_valid, req1_dividend, req1_divisor,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, quotient, remainder, div_by_zero, busy
    );

    modport slave (
        input  req0_valid, req0_dividend, req0_divisor,
        input  req1_valid, req1_dividend, req1_divisor,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, quotient, remainder, div_by_zero, busy
    );
endinterface

// File: rtl/div_arb_seq.sv
// Round-robin shared restoring divider (one quotient bit per cycle).
// Optional DIV_POW2_FASTPATH_EN: power-of-two divisors bypass CALC.
module div_arb_seq #(
    parameter int unsigned WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    div_arb_seq_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             id_q, id_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             grant0, grant1;
    logic [WIDTH-1:0] a_dvd, a_dvs;
    logic [WIDTH:0]   shifted;
    logic             pow2;
    logic [WIDTH-1:0] fp_quo;

`ifdef DIV_POW2_FASTPATH_EN
    always_comb begin
        pow2   = (a_dvs != '0) && ((a_dvs & (a_dvs - WIDTH'(1))) == '0);
        fp_quo = a_dvd;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (a_dvs[i]) fp_quo = a_dvd >> i;
        end
    end
`else
    always_comb begin
        pow2   = 1'b0;
        fp_quo = '0;
    end
`endif

    always_comb begin
        // ptr_q names the requester served last; the other one wins a tie
        grant0 = bus.req0_valid && (!bus.req1_valid || ptr_q);
        grant1 = bus.req1_valid && (!bus.req0_valid || !ptr_q);
        bus.req0_ready = rst_n && (state_q == IDLE) && grant0;
        bus.req1_ready = rst_n && (state_q == IDLE) && grant1;
        a_dvd = grant1 ? bus.req1_dividend : bus.req0_dividend;
        a_dvs = grant1 ? bus.req1_divisor  : bus.req0_divisor;

        // quo_q doubles as the dividend shift register during CALC
        shifted = {rem_q, quo_q[WIDTH-1]};

        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        dbz_d   = dbz_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req0_ready || bus.req1_ready) begin
                    ptr_d = bus.req1_ready;
                    id_d  = bus.req1_ready;
                    dvs_d = a_dvs;
                    cnt_d = '0;
                    dbz_d = 1'b0;
                    quo_d = a_dvd;
                    rem_d = '0;
                    if (a_dvs == '0) begin
                        quo_d   = '1;
                        rem_d   = a_dvd;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else if (pow2) begin
                        quo_d   = fp_quo;
                        rem_d   = a_dvd & (a_dvs - WIDTH'(1));
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (shifted >= {1'b0, dvs_q}) begin
                    rem_d = WIDTH'(shifted - {1'b0, dvs_q});
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
            end
            DONE: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 1'b1;
            id_q    <= 1'b0;
            dbz_q   <= 1'b0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            dbz_q   <= dbz_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        bus.resp_valid  = (state_q == DONE);
        bus.busy        = (state_q != IDLE);
        bus.resp_id     = id_q;
        bus.quotient    = quo_q;
        bus.remainder   = rem_q;
        bus.div_by_zero = dbz_q;
    end
endmodule
